// File: rtl/score_digit_entry_pkg.sv
// Shared types and constants for the decimal score entry block.
// Holds the FSM encoding, digit and accumulator sizing, and the saturation compare.
package score_digit_entry_pkg;

  localparam int unsigned     NUM_DIGITS = 3;
  localparam logic [7:0]      MAX_VALUE  = 8'd255;
  localparam logic [3:0]      DIGIT_MAX  = 4'd9;
  localparam int unsigned     ACC_W      = 10;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_CONV  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic acc_over(input logic [ACC_W-1:0] acc, input logic [7:0] lim);
    return acc > {{(ACC_W-8){1'b0}}, lim};
  endfunction

endpackage

// File: rtl/score_digit_entry_mac10.sv
// Combinational multiply-by-ten-and-add step used by the conversion loop.
// The x10 is built from two shifts so no multiplier is inferred.
module bcd_mac10
  import score_digit_entry_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  input  logic [3:0]       i_digit,
  output logic [ACC_W-1:0] o_sum
);

  logic [ACC_W-1:0] w_x8;
  logic [ACC_W-1:0] w_x2;

  assign w_x8  = i_acc << 3;
  assign w_x2  = i_acc << 1;
  assign o_sum = w_x8 + w_x2 + {{(ACC_W-4){1'b0}}, i_digit};

endmodule

// File: rtl/score_digit_entry.sv
// Keyed decimal entry (up to three digits) converted to a saturated 8-bit score,
// delivered over a valid/ready handshake; digits are echoed for the display decoders.
module score_digit_entry
  import score_digit_entry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = score_digit_entry_pkg::NUM_DIGITS,
  parameter logic [7:0]  MAX_VALUE  = score_digit_entry_pkg::MAX_VALUE
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] digit_in,
  input  logic       digit_push,
  input  logic       enter,
  input  logic       clear,
  input  logic       value_ready,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       overflow,
  output logic       busy,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_dig2, r_dig1, r_dig0;
  logic [3:0]       w_dig2_nxt, w_dig1_nxt, w_dig0_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_value, w_value_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_ovf, w_ovf_nxt;

  logic [3:0]       w_mac_digit;
  logic [ACC_W-1:0] w_mac_sum;
  logic             w_mac_over;

  always_comb begin
    case (r_idx)
      2'd2:    w_mac_digit = r_dig2;
      2'd1:    w_mac_digit = r_dig1;
      default: w_mac_digit = r_dig0;
    endcase
  end

  bcd_mac10 u_mac (
    .i_acc   (r_acc),
    .i_digit (w_mac_digit),
    .o_sum   (w_mac_sum)
  );

  assign w_mac_over = acc_over(w_mac_sum, MAX_VALUE);

  always_comb begin
    w_state_nxt = r_state;
    w_dig2_nxt  = r_dig2;
    w_dig1_nxt  = r_dig1;
    w_dig0_nxt  = r_dig0;
    w_acc_nxt   = r_acc;
    w_idx_nxt   = r_idx;
    w_value_nxt = r_value;
    w_valid_nxt = r_valid;
    w_ovf_nxt   = r_ovf;

    // clear overrides everything; value itself is left as last delivered
    if (clear) begin
      w_state_nxt = ST_ENTRY;
      w_dig2_nxt  = '0;
      w_dig1_nxt  = '0;
      w_dig0_nxt  = '0;
      w_acc_nxt   = '0;
      w_idx_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ENTRY: begin
          if (enter) begin
            w_state_nxt = ST_CONV;
            w_acc_nxt   = '0;
            w_idx_nxt   = LAST_IDX;
          end else if (digit_push && (digit_in <= DIGIT_MAX)) begin
            w_dig2_nxt = r_dig1;
            w_dig1_nxt = r_dig0;
            w_dig0_nxt = digit_in;
          end
        end
        ST_CONV: begin
          w_acc_nxt = w_mac_sum;
          w_idx_nxt = r_idx - 2'd1;
          if (r_idx == 2'd0) begin
            w_state_nxt = ST_DONE;
            w_value_nxt = w_mac_over ? MAX_VALUE : w_mac_sum[7:0];
            w_ovf_nxt   = w_mac_over;
            w_valid_nxt = 1'b1;
          end
        end
        ST_DONE: begin
          if (r_valid && value_ready) begin
            w_state_nxt = ST_ENTRY;
            w_valid_nxt = 1'b0;
            w_dig2_nxt  = '0;
            w_dig1_nxt  = '0;
            w_dig0_nxt  = '0;
          end
        end
        default: w_state_nxt = ST_ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_ENTRY;
      r_dig2  <= '0;
      r_dig1  <= '0;
      r_dig0  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dig2  <= w_dig2_nxt;
      r_dig1  <= w_dig1_nxt;
      r_dig0  <= w_dig0_nxt;
      r_acc   <= w_acc_nxt;
      r_idx   <= w_idx_nxt;
      r_value <= w_value_nxt;
      r_valid <= w_valid_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign value       = r_value;
  assign value_valid = r_valid;
  assign overflow    = r_ovf;
  assign busy        = (r_state != ST_ENTRY);
  assign dig2        = r_dig2;
  assign dig1        = r_dig1;
  assign dig0        = r_dig0;

endmodule

// File: tb/tb_score_digit_entry.sv
// Directed bench for score_digit_entry: a table of digit entries with expected
// echoes and results, plus hand-written reset, clear, collision and backpressure cases.
module tb_score_digit_entry;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] digit_in;
  logic       digit_push;
  logic       enter;
  logic       clear;
  logic       value_ready;
  logic [7:0] value;
  logic       value_valid;
  logic       overflow;
  logic       busy;
  logic [3:0] dig2, dig1, dig0;

  int n_chk = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  score_digit_entry #(.NUM_DIGITS(3), .MAX_VALUE(8'd255)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .digit_in    (digit_in),
    .digit_push  (digit_push),
    .enter       (enter),
    .clear       (clear),
    .value_ready (value_ready),
    .value       (value),
    .value_valid (value_valid),
    .overflow    (overflow),
    .busy        (busy),
    .dig2        (dig2),
    .dig1        (dig1),
    .dig0        (dig0)
  );

  typedef struct {
    int         n;
    logic [3:0] d [4];
    logic [3:0] e2, e1, e0;
    logic [7:0] ev;
    logic       eo;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    digit_in   = d;
    digit_push = 1'b1;
    tick();
    digit_push = 1'b0;
  endtask

  // Enter at edge T, then count edges until value_valid; expected count is 3.
  task automatic enter_and_wait(input string name);
    int cyc;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!value_valid && cyc < 12) begin
      tick();
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'd3);
  endtask

  task automatic accept(input string name, input logic [7:0] ev);
    value_ready = 1'b1;
    tick();
    value_ready = 1'b0;
    chk({name, "_acc_valid"}, 32'(value_valid), 32'd0);
    chk({name, "_acc_busy"}, 32'(busy), 32'd0);
    chk({name, "_acc_digs"}, {20'd0, dig2, dig1, dig0}, 32'd0);
    chk({name, "_acc_hold"}, 32'(value), 32'(ev));
  endtask

  task automatic set_vec(input int i, input int n, input int a, input int b, input int c,
                         input int d, input int e2, input int e1, input int e0,
                         input int ev, input int eo);
    vt[i].n    = n;
    vt[i].d[0] = 4'(a);
    vt[i].d[1] = 4'(b);
    vt[i].d[2] = 4'(c);
    vt[i].d[3] = 4'(d);
    vt[i].e2   = 4'(e2);
    vt[i].e1   = 4'(e1);
    vt[i].e0   = 4'(e0);
    vt[i].ev   = 8'(ev);
    vt[i].eo   = 1'(eo);
  endtask

  initial begin
    set_vec(0, 3, 2, 5, 5, 0,  2, 5, 5, 255, 0);
    set_vec(1, 3, 3, 0, 0, 0,  3, 0, 0, 255, 1);
    set_vec(2, 3, 9, 9, 9, 0,  9, 9, 9, 255, 1);
    set_vec(3, 1, 7, 0, 0, 0,  0, 0, 7,   7, 0);
    set_vec(4, 4, 1, 2, 3, 4,  2, 3, 4, 234, 0);
    set_vec(5, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0);
    set_vec(6, 4, 1, 2, 12, 8, 1, 2, 8, 128, 0);
    set_vec(7, 3, 2, 5, 6, 0,  2, 5, 6, 255, 1);

    resetn = 1'b0; digit_in = '0; digit_push = 1'b0;
    enter = 1'b0; clear = 1'b0; value_ready = 1'b0;
    tick();
    tick();
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_valid", 32'(value_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_digs", {20'd0, dig2, dig1, dig0}, 32'd0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      for (int k = 0; k < vt[i].n; k++) push(vt[i].d[k]);
      chk({nm, "_dig2"}, 32'(dig2), 32'(vt[i].e2));
      chk({nm, "_dig1"}, 32'(dig1), 32'(vt[i].e1));
      chk({nm, "_dig0"}, 32'(dig0), 32'(vt[i].e0));
      enter_and_wait(nm);
      chk({nm, "_value"}, 32'(value), 32'(vt[i].ev));
      chk({nm, "_ovf"}, 32'(overflow), 32'(vt[i].eo));
      accept(nm, vt[i].ev);
    end

    // Collision: enter wins over a push in the same cycle; pushes while busy ignored.
    push(4'd4);
    digit_in = 4'd5; digit_push = 1'b1; enter = 1'b1;
    tick();
    digit_push = 1'b0; enter = 1'b0;
    chk("coll_busy", 32'(busy), 32'd1);
    chk("coll_digs", {20'd0, dig2, dig1, dig0}, 32'h004);
    push(4'd6);
    chk("conv_push_digs", {20'd0, dig2, dig1, dig0}, 32'h004);
    tick();
    tick();
    chk("coll_valid", 32'(value_valid), 32'd1);
    chk("coll_value", 32'(value), 32'd4);
    push(4'd7);
    chk("done_push_digs", {20'd0, dig2, dig1, dig0}, 32'h004);

    // Backpressure: result held stable for 10 cycles, enter ignored.
    enter = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", 32'(value_valid), 32'd1);
      chk("bp_value", 32'(value), 32'd4);
      chk("bp_ovf", 32'(overflow), 32'd0);
    end
    enter = 1'b0;
    accept("bp", 8'd4);
    push(4'd3);
    chk("post_acc_push", 32'(dig0), 32'd3);

    // Clear sampled on the 2nd CONV cycle aborts with no result.
    push(4'd1); push(4'd2);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_digs", {20'd0, dig2, dig1, dig0}, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (value_valid) seen++;
      end
      chk("clr_no_valid", 32'(seen), 32'd0);
    end

    // Reset while DONE zeroes every output.
    push(4'd5); push(4'd0);
    enter_and_wait("rstd");
    chk("rstd_value", 32'(value), 32'd50);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rstd_value0", 32'(value), 32'd0);
    chk("rstd_valid0", 32'(value_valid), 32'd0);
    chk("rstd_busy0", 32'(busy), 32'd0);
    chk("rstd_digs0", {20'd0, dig2, dig1, dig0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
